program_fetch: RTL and testbench
================================

Name: program_fetch

Overview:
Reads program bytes out of the byte-wide program memory and hands them one at a time to the microprocessor's decode stage over a valid/ready stream. It scans upward from address 0 and stops at the 8'hFF end-of-program marker. It asserts running while a program is in flight and done once the program is exhausted. It also accepts branch redirects from the decode stage, flushing any prefetched bytes.

Parameters:
ADDR_W, 10, program memory address width (1024 bytes)
DATA_W, 8, program byte width
END_MARK, 8'hFF, end-of-program marker value
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset
enable  in  1  start request, level-sensitive
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en (1-cycle synchronous read)
byte_valid  out  1  byte_data/byte_addr valid
byte_data  out  DATA_W  program byte
byte_addr  out  ADDR_W  address of byte_data
byte_ready  in  1  consumer accepts byte (transfer = valid & ready)
redirect_valid  in  1  branch/jump request, single-cycle pulse
redirect_addr  in  ADDR_W  branch target
running  out  1  program in flight
done  out  1  program finished, sticky
overflow  out  1  address space exhausted without a marker, sticky

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, including mid-operation, forces: state IDLE, PC=0, FIFO empty, in-flight read dropped, every output 0.
- States:
  - IDLE: on enable=1, go to FETCH with PC=0 and epoch toggled.
  - FETCH: go to DRAIN on marker or overflow.
  - DRAIN: go to DONE when the FIFO is empty and no read is in flight.
  - DONE: on enable=0, go to IDLE.
- running = (state is FETCH or DRAIN). done = (state is DONE). overflow is set on wrap and cleared on entry to IDLE.
- Issue (FETCH only): mem_rd_en=1 when fifo_count + inflight + (pop this cycle ? -1 : 0) < FIFO_DEPTH. mem_addr=PC. On issue, PC increments.
- Return: the cycle after an issue, tag the read with the current epoch.
  - Tag matches and mem_rdata != END_MARK: push {mem_addr_of_read, mem_rdata} into the FIFO.
  - Tag matches and mem_rdata == END_MARK: no push, stop issuing, go to DRAIN. A read issued in the marker cycle is dropped by epoch toggle.
  - Tag does not match: discard.
- Latency: enable sampled high in IDLE at cycle T. mem_rd_en addr 0 at T+1. Byte 0 on byte_* at T+3. With byte_ready held high, sustained throughput is 1 byte/cycle.
- Output: byte_valid = FIFO non-empty. byte_data/byte_addr come from the FIFO head and are held stable while valid & !ready.
- Wrap: if the read at address 2^ADDR_W-1 returns a non-marker byte, push it, set overflow, stop issuing, go to DRAIN. No read of address 0 after wrap.
- Redirect (FETCH or DRAIN only; ignored in IDLE/DONE):
  - Next cycle: FIFO flushed, epoch toggled, PC=redirect_addr, state FETCH (clears pending marker/DRAIN).
  - byte_valid=0 during the cycle after the redirect. A transfer in the redirect cycle itself still completes.
- Simultaneous redirect and marker return: redirect wins, marker ignored.
- Simultaneous push and pop: both occur, count unchanged.
- enable dropping mid-program has no effect until DONE.
- Width rules: PC and address arithmetic are ADDR_W bits unsigned. Wrap is detected from the carry-out, never by comparing PC to 0.

Decomposition:
- Shared package pf_pkg: state enum {IDLE, FETCH, DRAIN, DONE}, END_MARK constant, ADDR_W/DATA_W defaults, struct fetch_entry_t {addr, data}.
- One sub-module: pf_fifo, a synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty, full.
- program_fetch holds the FSM, PC, epoch and in-flight tracking.

Test Plan:
- Memory {8'h12, 8'h34, 8'h56, 8'hFF}, enable=1, byte_ready=1 -> bytes 12/34/56 at addrs 0/1/2 on consecutive cycles starting T+3. running=1 from T+1. done=1 and running=0 after the last transfer. No byte with value FF is ever presented.
- Same memory, byte_ready toggling 1,0,0,1 -> no loss or duplication. byte_data stable while stalled. mem_rd_en never makes fifo_count+inflight exceed 2.
- Memory 00..09 then FF at 10. redirect_valid with redirect_addr=7 while byte at addr 2 is valid -> no byte from addrs 3..6 appears after the redirect cycle. Next bytes are addrs 7,8,9, then done.
- All 1024 bytes 8'h00, no marker -> 1024 bytes delivered (addrs 0..1023), then overflow=1 and done=1. mem_addr never returns to 0.
- rst=1 asserted while byte at addr 5 is pending -> next cycle all outputs 0 and state IDLE. Re-enable -> restart from addr 0.
- Marker at addr 3 arriving in the same cycle as redirect to addr 8 -> fetch continues from 8. No done until the marker at or beyond 8.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and defaults for the program fetch unit.
package pf_pkg;
  localparam int PF_ADDR_W = 10;
  localparam int PF_DATA_W = 8;
  localparam logic [PF_DATA_W-1:0] PF_END_MARK = 8'hFF;
  localparam int PF_FIFO_DEPTH = 2;

  typedef logic [1:0] pf_state_t;
  localparam pf_state_t IDLE  = 2'd0;
  localparam pf_state_t FETCH = 2'd1;
  localparam pf_state_t DRAIN = 2'd2;
  localparam pf_state_t DONE  = 2'd3;

  typedef struct packed {
    logic [PF_ADDR_W-1:0] addr;
    logic [PF_DATA_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/pf_fifo.sv
// Small synchronous prefetch FIFO of {addr, data} entries with flush.
module pf_fifo
  import pf_pkg::*;
#(
  parameter int DEPTH = PF_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full
);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage needs no reset; emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/program_fetch.sv
// Streams program bytes from memory to decode until the end marker,
// with epoch-tagged reads so redirects and markers drop stale data.
//   state | meaning
//   IDLE  | waiting for enable
//   FETCH | issuing reads, pushing returned bytes
//   DRAIN | no more reads; emptying FIFO and in-flight read
//   DONE  | program finished, waiting for enable low
module program_fetch
  import pf_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int DATA_W = PF_DATA_W,
  parameter logic [DATA_W-1:0] END_MARK = PF_END_MARK,
  parameter int FIFO_DEPTH = PF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic [ADDR_W-1:0] byte_addr,
  input  logic              byte_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              running,
  output logic              done,
  output logic              overflow
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  pf_state_t         state;
  logic [ADDR_W-1:0] pc, rd_addr;
  logic [ADDR_W:0]   pc_next;
  logic              epoch, rd_epoch, inflight, rd_wrap, pc_wrap, overflow_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_empty, fifo_full;
  fetch_entry_t      head, push_entry;
  logic              pop, push, issue, ret_ok, ret_mark, redir_take;

  assign redir_take = redirect_valid && (state == FETCH || state == DRAIN);
  assign pop        = !fifo_empty && byte_ready;
  assign occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue      = (state == FETCH) && !pc_wrap && !(fifo_full && !pop)
                      && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign pc_next    = {1'b0, pc} + 1'b1;

  // a redirect in the return cycle overrides whatever the read brought back
  assign ret_ok     = inflight && (rd_epoch == epoch) && !redir_take;
  assign ret_mark   = ret_ok && (mem_rdata == END_MARK);
  assign push       = ret_ok && (mem_rdata != END_MARK);
  assign push_entry = '{addr: rd_addr, data: mem_rdata};

  assign mem_rd_en  = issue;
  assign mem_addr   = pc;
  assign byte_valid = !fifo_empty;
  assign byte_data  = fifo_empty ? '0 : head.data;
  assign byte_addr  = fifo_empty ? '0 : head.addr;
  assign running    = (state == FETCH) || (state == DRAIN);
  assign done       = (state == DONE);
  assign overflow   = overflow_q;

  pf_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir_take),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      epoch      <= 1'b0;
      inflight   <= 1'b0;
      rd_epoch   <= 1'b0;
      rd_addr    <= '0;
      rd_wrap    <= 1'b0;
      pc_wrap    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_epoch <= epoch;
        rd_addr  <= pc;
        rd_wrap  <= pc_next[ADDR_W];
        pc       <= pc_next[ADDR_W-1:0];
        if (pc_next[ADDR_W]) pc_wrap <= 1'b1;
      end
      case (state)
        IDLE: if (enable) begin
          state   <= FETCH;
          pc      <= '0;
          epoch   <= ~epoch;
          pc_wrap <= 1'b0;
        end
        FETCH: if (ret_mark) begin
          state <= DRAIN;
          epoch <= ~epoch;
        end else if (push && rd_wrap) begin
          state      <= DRAIN;
          overflow_q <= 1'b1;
        end
        DRAIN: if (fifo_empty && !inflight) state <= DONE;
        DONE: if (!enable) begin
          state      <= IDLE;
          overflow_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (redir_take) begin
        state   <= FETCH;
        epoch   <= ~epoch;
        pc      <= redirect_addr;
        pc_wrap <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: a queue of expected {addr,data} bytes derived
// from memory contents is compared against the byte stream every cycle.
module tb_program_fetch;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NMEM = 1024;

  logic clk = 1'b0;
  logic rst, enable, mem_rd_en, byte_valid, byte_ready, redirect_valid;
  logic running, done, overflow;
  logic [AW-1:0] mem_addr, byte_addr, redirect_addr;
  logic [DW-1:0] mem_rdata, byte_data;
  logic [DW-1:0] mem [NMEM];

  int checks = 0;
  int failures = 0;
  int qa[$];
  int qd[$];
  logic busy = 1'b0, exp_ovf = 1'b0, after_redir = 1'b0, wrap_issued = 1'b0, done_seen = 1'b0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  program_fetch dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_addr(byte_addr),
    .byte_ready(byte_ready), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .running(running), .done(done),
    .overflow(overflow)
  );

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected program from start: bytes up to (not incl.) marker or end of memory
  function automatic void fill(input int start);
    int a = start;
    qa.delete(); qd.delete();
    exp_ovf = 1'b0; wait_cnt = 0;
    while (1) begin
      if (mem[a] == 8'hFF) break;
      qa.push_back(a); qd.push_back(int'(mem[a]));
      if (a == NMEM - 1) begin exp_ovf = 1'b1; break; end
      a++;
    end
  endfunction

  task automatic step();
    #1;
    if (!busy) begin
      chk("idle_running", int'(running), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_valid", int'(byte_valid), 0);
      chk("idle_rd_en", int'(mem_rd_en), 0);
    end else begin
      if (after_redir) chk("valid_after_redirect", int'(byte_valid), 0);
      if (wrap_issued) chk("read_after_wrap", int'(mem_rd_en), 0);
      if (qa.size() > 0) begin
        chk("running", int'(running), 1);
        chk("done_early", int'(done), 0);
        if (byte_valid) begin
          chk("byte_addr", int'(byte_addr), qa[0]);
          chk("byte_data", int'(byte_data), qd[0]);
        end
      end else begin
        chk("extra_byte", int'(byte_valid), 0);
        chk("running_xor_done", int'(running ^ done), 1);
        if (done) begin
          chk("overflow", int'(overflow), int'(exp_ovf));
          done_seen = 1'b1;
        end else wait_cnt++;
      end
    end
    if (busy && byte_valid && byte_ready && qa.size() > 0) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    after_redir = busy && redirect_valid;
    if (busy && mem_rd_en && int'(mem_addr) == NMEM - 1) wrap_issued = 1'b1;
    if (busy && redirect_valid) begin
      fill(int'(redirect_addr));
      wrap_issued = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic start();
    enable = 1'b1; redirect_valid = 1'b0;
    step();
    busy = 1'b1; after_redir = 1'b0; wrap_issued = 1'b0; done_seen = 1'b0;
    fill(0);
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1, 2: random ready/enable/redirects
  task automatic run_until_done(input int mode, input int redirs, input int max_cycles);
    int n = 0;
    int budget = redirs;
    done_seen = 1'b0;
    while (!done_seen && n < max_cycles && wait_cnt <= 16) begin
      redirect_valid = 1'b0;
      if (mode == 0) byte_ready = 1'b1;
      else if (mode == 1) byte_ready = (n % 4 == 0) || (n % 4 == 3);
      else begin
        byte_ready = 1'($urandom_range(0, 1));
        enable = (qa.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (budget > 0 && qa.size() > 0 && $urandom_range(0, 19) == 0) begin
          redirect_valid = 1'b1;
          redirect_addr = AW'($urandom_range(0, 90));
          budget--;
        end
      end
      step();
      n++;
    end
    redirect_valid = 1'b0; enable = 1'b1;
    chk("done_reached", int'(done_seen), 1);
  endtask

  task automatic finish_run();
    enable = 1'b0;
    step();
    busy = 1'b0;
    step();
    chk("overflow_cleared", int'(overflow), 0);
  endtask

  task automatic check_zero(input string tag);
    #1;
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_valid"}, int'(byte_valid), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_byte_addr"}, int'(byte_addr), 0);
    chk({tag, "_byte_data"}, int'(byte_data), 0);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < NMEM; a++) mem[a] = 8'hFF;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; byte_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    step();

    // basic program 12 34 56 FF with literal latency pins
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'hFF;
    byte_ready = 1'b1;
    start();
    #1;
    chk("lat_rd_en_t1", int'(mem_rd_en), 1);
    chk("lat_addr_t1", int'(mem_addr), 0);
    chk("lat_running_t1", int'(running), 1);
    step(); step();
    #1;
    chk("lat_valid_t3", int'(byte_valid), 1);
    chk("lat_data_t3", int'(byte_data), 8'h12);
    step();
    #1;
    chk("lat_data_t4", int'(byte_data), 8'h34);
    step();
    #1;
    chk("lat_data_t5", int'(byte_data), 8'h56);
    chk("lat_addr_t5", int'(byte_addr), 2);
    run_until_done(0, 0, 50);
    finish_run();

    // same program with ready stalls
    byte_ready = 1'b1;
    start();
    run_until_done(1, 0, 80);
    finish_run();

    // redirect to 7 while byte at addr 2 is presented
    clear_mem();
    for (int a = 0; a < 10; a++) mem[a] = 8'(a);
    byte_ready = 1'b1;
    start();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_addr = AW'(7);
    #1;
    chk("redir_pre_addr", int'(byte_addr), 2);
    step();
    redirect_valid = 1'b0;
    step(); step();
    #1;
    chk("redir_first_addr", int'(byte_addr), 7);
    chk("redir_first_valid", int'(byte_valid), 1);
    run_until_done(0, 0, 50);
    finish_run();

    // marker at 3 returns in the same cycle as a redirect to 8
    clear_mem();
    for (int a = 0; a < 12; a++) mem[a] = 8'(8'h20 + a);
    mem[3] = 8'hFF;
    byte_ready = 1'b1;
    start();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_addr = AW'(8);
    step();
    redirect_valid = 1'b0;
    step(); step();
    #1;
    chk("mark_redir_addr", int'(byte_addr), 8);
    chk("mark_redir_data", int'(byte_data), 8'h28);
    run_until_done(0, 0, 50);
    finish_run();

    // no marker anywhere: full address space then overflow
    for (int a = 0; a < NMEM; a++) mem[a] = 8'h00;
    byte_ready = 1'b1;
    start();
    run_until_done(0, 0, 1200);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_all_bytes", qa.size(), 0);
    finish_run();

    // reset while byte at addr 5 is pending, then restart
    clear_mem();
    for (int a = 0; a < 40; a++) mem[a] = 8'(a + 1);
    byte_ready = 1'b1;
    start();
    repeat (7) step();
    byte_ready = 1'b0; rst = 1'b1; enable = 1'b0;
    #1;
    chk("rst_pending_addr", int'(byte_addr), 5);
    step();
    busy = 1'b0; qa.delete(); qd.delete();
    check_zero("midrst");
    rst = 1'b0;
    step();
    byte_ready = 1'b1;
    start();
    step(); step();
    #1;
    chk("restart_addr", int'(byte_addr), 0);
    chk("restart_data", int'(byte_data), 1);
    run_until_done(0, 0, 80);
    finish_run();

    // randomized programs with stalls, enable noise and redirects
    for (int r = 0; r < 8; r++) begin
      clear_mem();
      for (int a = 0; a < 80; a++)
        mem[a] = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      start();
      run_until_done(2, 4, 3000);
      finish_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
